// File: rtl/run_controller.sv
// run_controller -- sequences a core through reset, a go delay and a monitored run.
//
// A one-cycle start pulse holds the core in reset for RST_CYCLES cycles, waits
// GO_DELAY cycles with reset released, then raises go_contr.
// The run ends on one of two events:
//   - HALT: the core's instruction register shows HALT_WORD.
//   - TIMEOUT: TIMEOUT_CYCLES run cycles elapse (0 disables this).
// HALT wins if both happen on the same edge.
// All outputs are registered.
//
// Optional feature: define RUN_CTRL_INSTR_COUNT_EN to count instruction
// changes during the run. Without it, instr_count is tied to 0.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   reset        in   asynchronous active-high reset
//   start        in   one-cycle run request (honoured in IDLE/HALT/TIMEOUT)
//   ir_in        in   [31:0] core instruction register
//   core_reset   out  reset to the core
//   go_contr     out  run enable to the core
//   busy         out  high in RST_HOLD, GO_DLY, RUN
//   halted       out  last run ended on HALT_WORD
//   timeout      out  last run ended on the cycle limit
//   cycle_count  out  [31:0] run cycles in current/last run (saturating)
//   instr_count  out  [31:0] instruction changes in current/last run (saturating)
module run_controller #(
   parameter int unsigned RST_CYCLES     = 2,
   parameter int unsigned GO_DELAY       = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1500,
   parameter logic [31:0] HALT_WORD      = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] ir_in,
   output logic        core_reset,
   output logic        go_contr,
   output logic        busy,
   output logic        halted,
   output logic        timeout,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_count
);

   typedef enum logic [2:0] {
      StIdle,
      StRstHold,
      StGoDly,
      StRun,
      StHalt,
      StTimeout
   } state_e;

   // A zero reset hold is stretched to one cycle so the core always sees reset.
   localparam int unsigned RstEff   = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
   localparam logic [31:0] RstLast  = 32'(RstEff - 1);
   // Only meaningful when GO_DELAY != 0; GO_DLY is skipped otherwise.
   localparam logic [31:0] GoLast   = 32'(GO_DELAY - 1);
   localparam logic [31:0] ToLast   = 32'(TIMEOUT_CYCLES - 1);
   localparam bit          ToEn     = (TIMEOUT_CYCLES != 0);
   localparam bit          SkipGo   = (GO_DELAY == 0);

   state_e      state_q;
   logic [31:0] dly_q;

   logic        enter_rst;
   logic        enter_run;
   logic        halt_hit;
   logic        to_hit;
   logic [31:0] cycle_inc;

   always_comb begin
      enter_rst = start && ((state_q == StIdle) || (state_q == StHalt) ||
                            (state_q == StTimeout));
      enter_run = ((state_q == StRstHold) && (dly_q == RstLast) && SkipGo) ||
                  ((state_q == StGoDly) && (dly_q == GoLast));
      halt_hit  = (ir_in == HALT_WORD);
      to_hit    = ToEn && (cycle_count == ToLast);
      cycle_inc = (cycle_count == 32'hFFFFFFFF) ? cycle_count : cycle_count + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         dly_q       <= '0;
         core_reset  <= 1'b1;
         go_contr    <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
      end else begin
         case (state_q)
            StIdle, StHalt, StTimeout: begin
               if (enter_rst) begin
                  state_q     <= StRstHold;
                  dly_q       <= '0;
                  core_reset  <= 1'b1;
                  go_contr    <= 1'b0;
                  busy        <= 1'b1;
                  halted      <= 1'b0;
                  timeout     <= 1'b0;
                  cycle_count <= '0;
               end
            end
            StRstHold: begin
               if (dly_q == RstLast) begin
                  dly_q      <= '0;
                  core_reset <= 1'b0;
                  if (enter_run) begin
                     state_q  <= StRun;
                     go_contr <= 1'b1;
                  end else begin
                     state_q  <= StGoDly;
                  end
               end else begin
                  dly_q <= dly_q + 32'd1;
               end
            end
            StGoDly: begin
               if (enter_run) begin
                  state_q  <= StRun;
                  go_contr <= 1'b1;
               end else begin
                  dly_q <= dly_q + 32'd1;
               end
            end
            StRun: begin
               // The exit edge is itself a run cycle, so it is counted too.
               cycle_count <= cycle_inc;
               if (halt_hit) begin
                  state_q  <= StHalt;
                  go_contr <= 1'b0;
                  busy     <= 1'b0;
                  halted   <= 1'b1;
               end else if (to_hit) begin
                  state_q  <= StTimeout;
                  go_contr <= 1'b0;
                  busy     <= 1'b0;
                  timeout  <= 1'b1;
               end
            end
            default: begin
               state_q    <= StIdle;
               core_reset <= 1'b1;
               go_contr   <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

`ifdef RUN_CTRL_INSTR_COUNT_EN
   logic [31:0] ir_prev_q;

   // Sampler is preloaded on the edge entering RUN so the first run cycle
   // only counts a change that happens after the core was released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_prev_q   <= '0;
         instr_count <= '0;
      end else if (enter_rst) begin
         instr_count <= '0;
      end else if (enter_run) begin
         ir_prev_q <= ir_in;
      end else if (state_q == StRun) begin
         ir_prev_q <= ir_in;
         if ((ir_in != ir_prev_q) && (instr_count != 32'hFFFFFFFF)) begin
            instr_count <= instr_count + 32'd1;
         end
      end
   end
`else
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller. Two instances share stimulus: one with
// default parameters and one with TIMEOUT_CYCLES=5. Expected values are pushed
// to a scoreboard as stimulus is driven and popped when outputs are sampled,
// 1 time unit after the rising edge.
module tb_run_controller;

   localparam logic [31:0] HALT = 32'hFFFFFFFF;
   localparam logic [31:0] VA   = 32'h0000_1111;
   localparam logic [31:0] VB   = 32'h0000_2222;
   localparam logic [31:0] VC   = 32'h0000_3333;

`ifdef RUN_CTRL_INSTR_COUNT_EN
   localparam bit IcEn = 1'b1;
`else
   localparam bit IcEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] ir_in;

   logic        core_reset, go_contr, busy, halted, timeout;
   logic [31:0] cycle_count, instr_count;
   logic        t5_core_reset, t5_go_contr, t5_busy, t5_halted, t5_timeout;
   logic [31:0] t5_cycle_count, t5_instr_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   run_controller dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .ir_in       (ir_in),
      .core_reset  (core_reset),
      .go_contr    (go_contr),
      .busy        (busy),
      .halted      (halted),
      .timeout     (timeout),
      .cycle_count (cycle_count),
      .instr_count (instr_count)
   );

   run_controller #(.TIMEOUT_CYCLES(5)) dut5 (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .ir_in       (ir_in),
      .core_reset  (t5_core_reset),
      .go_contr    (t5_go_contr),
      .busy        (t5_busy),
      .halted      (t5_halted),
      .timeout     (t5_timeout),
      .cycle_count (t5_cycle_count),
      .instr_count (t5_instr_count)
   );

   // halted and timeout must never be seen together on either instance.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         checks++;
         assert (!((halted && timeout) || (t5_halted && t5_timeout))) else begin
            errors++;
            $error("FAIL excl observed h=%b t=%b h5=%b t5=%b required not both",
                   halted, timeout, t5_halted, t5_timeout);
         end
      end
   end

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL sb_underflow observed %0h required queued expectation", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic push_dut(input string tag, input logic cr, input logic go, input logic bsy,
                           input logic h, input logic t, input logic [31:0] cc);
      push({tag, ".core_reset"},  {31'b0, cr});
      push({tag, ".go_contr"},    {31'b0, go});
      push({tag, ".busy"},        {31'b0, bsy});
      push({tag, ".halted"},      {31'b0, h});
      push({tag, ".timeout"},     {31'b0, t});
      push({tag, ".cycle_count"}, cc);
   endtask

   task automatic chk_dut();
      chk({31'b0, core_reset});
      chk({31'b0, go_contr});
      chk({31'b0, busy});
      chk({31'b0, halted});
      chk({31'b0, timeout});
      chk(cycle_count);
   endtask

   task automatic push5(input string tag, input logic h, input logic t,
                        input logic [31:0] cc, input logic go);
      push({tag, ".t5_halted"},      {31'b0, h});
      push({tag, ".t5_timeout"},     {31'b0, t});
      push({tag, ".t5_cycle_count"}, cc);
      push({tag, ".t5_go_contr"},    {31'b0, go});
   endtask

   task automatic chk5();
      chk({31'b0, t5_halted});
      chk({31'b0, t5_timeout});
      chk(t5_cycle_count);
      chk({31'b0, t5_go_contr});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start pulse, then walk through RST_HOLD (2), GO_DLY (1) into RUN cycle 1.
   task automatic start_run(input string tag);
      start = 1'b1;
      push_dut({tag, "_hold1"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      push5({tag, "_hold1"}, 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
      chk_dut();
      chk5();
      start = 1'b0;
      push_dut({tag, "_hold2"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      chk_dut();
      push_dut({tag, "_godly"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      chk_dut();
      push_dut({tag, "_run1"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      chk_dut();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      ir_in = VA;
      #2;
      push_dut("por", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      push("por.instr_count", 32'd0);
      chk_dut();
      chk(instr_count);
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();

      // Run 1: start ignored mid-run, halt presented in RUN cycle 10.
      start_run("r1");
      repeat (3) tick();
      start = 1'b1;
      push_dut("r1_ignore", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd4);
      tick();
      chk_dut();
      start = 1'b0;
      repeat (5) tick();
      ir_in = HALT;
      push_dut("r1_halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd10);
      push5("r1_t5_timeout", 1'b0, 1'b1, 32'd5, 1'b0);
      tick();
      chk_dut();
      chk5();
      ir_in = VA;
      push_dut("r1_frozen", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd10);
      tick();
      chk_dut();

      // Run 2: restart from HALT, instruction sequence A,A,B,C,C,HALT.
      start_run("r2");
      ir_in = VA;
      tick();
      ir_in = VA;
      tick();
      ir_in = VB;
      tick();
      ir_in = VC;
      tick();
      ir_in = VC;
      tick();
      ir_in = HALT;
      push_dut("r2_halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6);
      push("r2_halt.instr_count", IcEn ? 32'd3 : 32'd0);
      push5("r2_t5", 1'b0, 1'b1, 32'd5, 1'b0);
      tick();
      chk_dut();
      chk(instr_count);
      chk5();
      ir_in = VA;

      // Run 3: halt in RUN cycle 5 coincides with the 5-cycle limit; halt wins.
      start_run("r3");
      repeat (4) tick();
      ir_in = HALT;
      push5("r3_t5_tie", 1'b1, 1'b0, 32'd5, 1'b0);
      push_dut("r3_halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
      push("r3_halt.instr_count", IcEn ? 32'd1 : 32'd0);
      tick();
      chk5();
      chk_dut();
      chk(instr_count);
      ir_in = VA;

      // Run 4: reset mid-run aborts at once with no end indication.
      start_run("r4");
      ir_in = VB;
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      push_dut("r4_abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      push("r4_abort.instr_count", 32'd0);
      push5("r4_abort_t5", 1'b0, 1'b0, 32'd0, 1'b0);
      chk_dut();
      chk(instr_count);
      chk5();
      tick();
      reset = 1'b0;
      ir_in = VA;
      push_dut("r4_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      chk_dut();

      // Run 5: no halt, default 1500-cycle limit.
      start_run("r5");
      repeat (1499) tick();
      push_dut("r5_last_run", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1499);
      chk_dut();
      push_dut("r5_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1500);
      tick();
      chk_dut();
      push_dut("r5_frozen", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1500);
      tick();
      chk_dut();

      // Restart from TIMEOUT clears the flags.
      start = 1'b1;
      push_dut("r6_restart", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      chk_dut();
      start = 1'b0;

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_leftover observed %0d required 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter RST_CYCLES, default 2, cycles core_reset is held after start.
REQ-002 Parameter GO_DELAY, default 1, cycles between core_reset release and go_contr assertion.
REQ-003 Parameter TIMEOUT_CYCLES, default 1500, RUN-state cycle limit; 0 disables timeout.
REQ-004 Parameter HALT_WORD, default 32'hFFFFFFFF, instruction value that ends a run.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a run.
REQ-008 ir_in  input  32  core instruction register (core irOut).
REQ-009 core_reset  output  1  reset driven to the core.
REQ-010 go_contr  output  1  run enable driven to the core.
REQ-011 busy  output  1  high in RST_HOLD, GO_DLY, RUN.
REQ-012 halted  output  1  run ended on HALT_WORD.
REQ-013 timeout  output  1  run ended on cycle limit.
REQ-014 cycle_count  output  32  RUN cycles elapsed in current/last run.
REQ-015 instr_count  output  32  instruction changes observed in current/last run.

Function
REQ-016 All outputs SHALL be registered (Moore, decoded from state and counters).
REQ-017 States SHALL be IDLE, RST_HOLD, GO_DLY, RUN, HALT, TIMEOUT.
REQ-018 IDLE: core_reset=1, go_contr=0; start -> RST_HOLD.
REQ-019 RST_HOLD: core_reset=1 for exactly RST_CYCLES cycles (min 1), then -> GO_DLY; entry clears cycle_count, instr_count, halted, timeout.
REQ-020 GO_DLY: core_reset=0, go_contr=0 for exactly GO_DELAY cycles (0 skips state), then -> RUN.
REQ-021 RUN: go_contr=1, core_reset=0; cycle_count increments by 1 each RUN cycle, saturating at 32'hFFFFFFFF.
REQ-022 RUN: ir_in==HALT_WORD sampled on a clock edge -> HALT next cycle; halted=1, go_contr=0.
REQ-023 RUN: cycle_count==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES!=0 -> TIMEOUT next cycle; timeout=1, go_contr=0.
REQ-024 Halt and timeout in the same cycle: halt SHALL win; timeout stays 0.
REQ-025 HALT/TIMEOUT: core_reset=0, counters frozen; start -> RST_HOLD (restart).
REQ-026 start SHALL be ignored in RST_HOLD, GO_DLY, RUN.
REQ-027 halted and timeout SHALL never be 1 simultaneously.

Reset
REQ-028 reset SHALL asynchronously force IDLE, core_reset=1, go_contr=0, busy=0, halted=0, timeout=0, cycle_count=0, instr_count=0.
REQ-029 reset mid-run SHALL abort immediately with no HALT/TIMEOUT indication.

Configuration
REQ-030 Macro RUN_CTRL_INSTR_COUNT_EN defined: in RUN, instr_count increments (saturating) on each cycle where ir_in differs from its previous-cycle sample; sampler preloaded at RUN entry with ir_in.
REQ-031 Macro undefined: instr_count port present, constant 0, no counter or sampler logic.

Verification
REQ-032 reset pulse, start at cycle 3 -> core_reset high 2 cycles, low 1 cycle with go_contr=0, then go_contr=1, busy=1.
REQ-033 In RUN drive ir_in=32'hFFFFFFFF after 10 RUN cycles -> next cycle halted=1, go_contr=0, cycle_count=10 held.
REQ-034 ir_in never HALT_WORD, TIMEOUT_CYCLES=1500 -> timeout=1 after 1500 RUN cycles, cycle_count=1500, go_contr=0.
REQ-035 TIMEOUT_CYCLES=5, HALT_WORD presented on 5th RUN cycle -> halted=1, timeout=0.
REQ-036 reset asserted mid-RUN -> same-cycle core_reset=1, go_contr=0, counters 0; start in HALT -> new run, flags cleared.
REQ-037 Macro defined, ir_in sequence A,A,B,C,C,HALT_WORD -> instr_count=3 on halt; undefined -> 0.
